pw_bit_rx: RTL and testbench

PW_BIT_RX -- requirements
Module: pw_bit_rx

---
 rtl/pw_bit_rx.sv | 174 +++++++++++++++++
 tb/tb_pw_bit_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_bit_rx.sv
// Pulse-width-encoded serial receiver: high time >= threshold decodes as 1, words leave on AXI-Stream.
// Define PW_BIT_RX_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pw_bit_rx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  rxd,
   input  logic                  cfg_enable,
   input  logic [CNT_WIDTH-1:0]  cfg_threshold,
   input  logic [CNT_WIDTH-1:0]  cfg_timeout,
   input  logic [5:0]            cfg_nbits,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  frame_err,
   output logic                  overrun
);
   localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t                state, state_next;
   logic                  rxd_meta, rxd_s, line, line_d, rise, fall;
   logic [CNT_WIDTH-1:0]  cnt, cnt_next, cnt_inc;
   logic [BCW-1:0]        bit_cnt, bit_cnt_next, bit_cnt_inc, eff_nbits;
   logic [DATA_WIDTH-1:0] shreg, shreg_next;
   logic                  bit_val, word_done, err_next, timed_out;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rxd_meta <= 1'b0;
         rxd_s    <= 1'b0;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

`ifdef PW_BIT_RX_GLITCH_FILTER_EN
   logic hist1, hist2, filt_q, agree;

   // Output follows the line only once three consecutive samples agree.
   assign agree = (rxd_s == hist1) && (hist1 == hist2);
   assign line  = agree ? rxd_s : filt_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         hist1  <= 1'b0;
         hist2  <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         hist1  <= rxd_s;
         hist2  <= hist1;
         filt_q <= line;
      end
   end
`else
   assign line = rxd_s;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) line_d <= 1'b0;
      else          line_d <= line;
   end

   assign rise        = line & ~line_d;
   assign fall        = ~line & line_d;
   assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
   assign bit_cnt_inc = bit_cnt + BCW'(1);
   assign timed_out   = (cfg_timeout != '0) && (cnt >= cfg_timeout);

   always_comb begin
      if (cfg_nbits == '0 || 32'(cfg_nbits) > DATA_WIDTH) eff_nbits = BCW'(DATA_WIDTH);
      else                                                eff_nbits = BCW'(cfg_nbits);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_cnt <= bit_cnt_next;
         shreg   <= shreg_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      bit_val      = 1'b0;
      word_done    = 1'b0;
      err_next     = 1'b0;
      if (!cfg_enable) begin
         state_next   = IDLE;
         cnt_next     = '0;
         bit_cnt_next = '0;
         shreg_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_next   = HIGH;
                  cnt_next     = CNT_WIDTH'(1);
                  bit_cnt_next = '0;
                  shreg_next   = '0;
               end
            end
            HIGH: begin
               if (fall) begin
                  bit_val      = (cnt >= cfg_threshold);
                  shreg_next   = (shreg << 1) | DATA_WIDTH'(bit_val);
                  bit_cnt_next = bit_cnt_inc;
                  cnt_next     = CNT_WIDTH'(1);
                  if (bit_cnt_inc == eff_nbits) begin
                     word_done  = 1'b1;
                     state_next = IDLE;
                  end else begin
                     state_next = LOW;
                  end
               end else if (timed_out) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            LOW: begin
               if (rise) begin
                  state_next = HIGH;
                  cnt_next   = CNT_WIDTH'(1);
               end else if (timed_out) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // A completing word may replace the held one only when it is being accepted this cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_err <= err_next;
         overrun   <= 1'b0;
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
         if (word_done) begin
            if (!m_axis_tvalid || m_axis_tready) begin
               m_axis_tdata  <= shreg_next;
               m_axis_tvalid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pw_bit_rx.sv
// Scoreboard bench for pw_bit_rx: pulse lists are decoded by a behavioural model into expected words.
`timescale 1ns/1ps
module tb_pw_bit_rx;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        rxd = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [15:0] thr = 16'd60;
   logic [15:0] tmo = 16'd300;
   logic [5:0]  nbits = 6'd8;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready = 1'b1;
   logic        frame_err, overrun;

   always #5 aclk = ~aclk;

   pw_bit_rx #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn), .rxd(rxd), .cfg_enable(cfg_enable),
      .cfg_threshold(thr), .cfg_timeout(tmo), .cfg_nbits(nbits),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .frame_err(frame_err), .overrun(overrun)
   );

   int n_checks = 0, n_fail = 0;
   int act_beats = 0, act_err = 0, act_ovr = 0;
   int exp_beats = 0, exp_err = 0, exp_ovr = 0;
   int cyc = 0, last_err_cyc = 0, fall_cyc = 0;
   logic [31:0] exp_q[$];
   int hq[$], lq[$];

   always @(posedge aclk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted beat and counts pulses.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (frame_err) begin
            act_err++;
            last_err_cyc = cyc;
         end
         if (overrun) act_ovr++;
         if (tvalid && tready) begin
            act_beats++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", tdata);
            end else begin
               check("tdata", tdata, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Reference: every high pulse is one bit; bits group into words of the effective length.
   task automatic model_burst();
      int bits[$];
      int eff;
      logic [31:0] w;
      eff = (nbits == 0 || nbits > 32) ? 32 : int'(nbits);
      for (int i = 0; i < hq.size(); i++) begin
`ifdef PW_BIT_RX_GLITCH_FILTER_EN
         if (hq[i] < 3) continue;
`endif
         bits.push_back((hq[i] >= int'(thr)) ? 1 : 0);
      end
      while (bits.size() >= eff) begin
         w = '0;
         for (int k = 0; k < eff; k++) w = (w << 1) | 32'(bits.pop_front());
         if (!tready && exp_q.size() > 0) exp_ovr++;
         else begin
            exp_q.push_back(w);
            exp_beats++;
         end
      end
      if (bits.size() > 0 && tmo != 0) exp_err++;
   endtask

   task automatic send_burst();
      model_burst();
      for (int i = 0; i < hq.size(); i++) begin
         rxd = 1'b1;
         tick(hq[i]);
         rxd = 1'b0;
         fall_cyc = cyc;
         tick(lq[i]);
      end
      hq.delete();
      lq.delete();
   endtask

   task automatic add_word(input logic [31:0] v, input int n, input int h1, input int h0, input int per);
      for (int k = n - 1; k >= 0; k--) begin
         int h;
         h = v[k] ? h1 : h0;
         hq.push_back(h);
         lq.push_back(per - h);
      end
   endtask

   task automatic raw_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         rxd = 1'b1;
         tick(80);
         rxd = 1'b0;
         tick(45);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         tick(1);
         k++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_beats"}, act_beats, exp_beats);
      check({tag, "_frame_err"}, act_err, exp_err);
      check({tag, "_overrun"}, act_ovr, exp_ovr);
   endtask

   initial begin
      int d, eff, hi;
      logic [31:0] word;
      cfg_enable = 1'b1;
      tick(3);
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      aresetn = 1'b1;
      tick(5);

      add_word(32'hA5, 8, 80, 40, 125);
      send_burst();
      wait_drain("a5_drain", 50);
      check_counts("a5");

      nbits = 6'd2;
      hq.push_back(59); lq.push_back(66);
      hq.push_back(60); lq.push_back(65);
      send_burst();
      wait_drain("thr_drain", 50);
      nbits = 6'd32;
      add_word(32'hDEADBEEF, 32, 80, 40, 125);
      send_burst();
      wait_drain("deadbeef_drain", 50);
      check_counts("thr");

      nbits = 6'd8;
      tready = 1'b0;
      add_word(32'h3C, 8, 80, 40, 125);
      send_burst();
      check("hold_tvalid", tvalid, 1);
      check("hold_tdata", tdata, 32'h3C);
      add_word(32'hC3, 8, 80, 40, 125);
      send_burst();
      check("ovr_tdata", tdata, 32'h3C);
      check("ovr_count", act_ovr, exp_ovr);
      tready = 1'b1;
      wait_drain("ovr_drain", 20);
      tick(20);
      check_counts("ovr");

      add_word(32'hB, 4, 80, 40, 125);
      lq[3] = 400;
      send_burst();
      d = last_err_cyc - fall_cyc;
      check("timeout_latency_in_300_306", (d >= 300 && d <= 306), 1);
      add_word(32'h01, 8, 80, 40, 125);
      send_burst();
      wait_drain("after_timeout_drain", 50);
      check_counts("timeout");

      raw_pulses(3);
      tick(10);
      cfg_enable = 1'b0;
      tick(2);
      cfg_enable = 1'b1;
      tick(400);
      add_word(32'h5A, 8, 80, 40, 125);
      send_burst();
      wait_drain("enable_drain", 50);
      check_counts("enable");

      tready = 1'b0;
      add_word(32'h77, 8, 80, 40, 125);
      send_burst();
      raw_pulses(3);
      aresetn = 1'b0;
      tick(1);
      aresetn = 1'b1;
      check("midrst_tvalid", tvalid, 0);
      check("midrst_tdata", tdata, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_overrun", overrun, 0);
      exp_q.delete();
      exp_beats--;
      tready = 1'b1;
      tick(400);
      add_word(32'h81, 8, 80, 40, 125);
      send_burst();
      wait_drain("midrst_drain", 50);
      check_counts("midrst");

      add_word(32'hA5, 8, 80, 40, 125);
      lq[3] = 40;
      hq.insert(4, 2);
      lq.insert(4, 43);
      lq[8] = 400;
      send_burst();
      wait_drain("glitch_drain", 50);
      check_counts("glitch");

      for (int it = 0; it < 16; it++) begin
         thr   = 16'($urandom_range(20, 60));
         nbits = 6'($urandom_range(0, 40));
         tmo   = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'd300;
         eff   = (nbits == 0 || nbits > 32) ? 32 : int'(nbits);
         word  = $urandom;
         for (int k = eff - 1; k >= 0; k--) begin
            hi = word[k] ? $urandom_range(int'(thr), int'(thr) + 30) : $urandom_range(3, int'(thr) - 1);
            hq.push_back(hi);
            lq.push_back($urandom_range(3, 15));
         end
         lq[eff - 1] = 30;
         send_burst();
         wait_drain("rand_drain", 50);
      end
      check_counts("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
